// File: rtl/or_gate_pkg.sv
// rtl/or_gate_pkg.sv - shared state encoding, limits and run-length helper for the OR gate checker
package or_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MAX_N_IN = 8;

    // Cycles from the accepted start edge to done rising for a full run.
    function automatic int cycles_per_run(input int n_in, input int settle_cyc);
        return (1 << n_in) * (settle_cyc + 1);
    endfunction

endpackage

// File: rtl/or_gate_ref.sv
// rtl/or_gate_ref.sv - combinational golden OR-reduction used as the expected gate output
module or_gate_ref #(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] in_vec,
    output logic            y
);

    assign y = |in_vec;

endmodule

// File: rtl/or_gate_checker.sv
// rtl/or_gate_checker.sv - exhaustive OR gate self-test engine; optional OR_GATE_CHECKER_STOP_ON_FAIL_EN
// ends the run at the first mismatch
module or_gate_checker
    import or_gate_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYC - 1);
    // Termination is by compare against the last pattern; the extra MSB never sets.
    localparam logic [N_IN:0] LAST_PAT = {1'b0, {N_IN{1'b1}}};

    state_t            state_q, state_d;
    logic [N_IN:0]     pattern_q, pattern_d;
    logic [CW-1:0]     settle_q, settle_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_cnt_q, err_cnt_d;
    logic              ff_valid_q, ff_valid_d;
    logic [N_IN-1:0]   ff_vec_q, ff_vec_d;

    logic expected;
    logic mismatch;
    logic stop_now;

    or_gate_ref #(.N_IN(N_IN)) u_ref (
        .in_vec (pattern_q[N_IN-1:0]),
        .y      (expected)
    );

    assign mismatch = (dut_y != expected);

`ifdef OR_GATE_CHECKER_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        settle_d   = settle_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    pattern_d  = '0;
                    settle_d   = SETTLE_RELOAD;
                    err_cnt_d  = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = pattern_q[N_IN-1:0];
                    end
                end
                if (pattern_q == LAST_PAT || stop_now) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d   = SETTLE;
                    pattern_d = pattern_q + 1'b1;
                    settle_d  = SETTLE_RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            settle_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    assign dut_in           = pattern_q[N_IN-1:0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_or_gate_checker.sv
// tb/tb_or_gate_checker.sv - self-checking bench for or_gate_checker with a truth-table driven gate and
// a cycle-count reference model; OR_GATE_CHECKER_STOP_ON_FAIL_EN selects the stop-on-fail scenario
module tb_or_gate_checker;

`ifdef OR_GATE_CHECKER_STOP_ON_FAIL_EN
    localparam int N = 3;
    localparam int S = 2;
`else
    localparam int N = 2;
    localparam int S = 1;
`endif
    localparam int NP = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dut_in;
    logic         dut_y;
    logic         busy, done, pass, first_fail_valid;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_fail_vec;
    logic [255:0] gate_tt = '0;

    int n_checks = 0;
    int n_fail = 0;

    assign dut_y = gate_tt[dut_in];

    always #5 clk = ~clk;

    or_gate_checker #(.N_IN(N), .SETTLE_CYC(S)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dut_in           (dut_in),
        .dut_y            (dut_y),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [255:0] tt, input int p);
        return tt[p] != (p != 0);
    endfunction

    function automatic int run_len(input logic [255:0] tt);
`ifdef OR_GATE_CHECKER_STOP_ON_FAIL_EN
        for (int p = 0; p < NP; p++)
            if (is_bad(tt, p)) return (p + 1) * (S + 1);
`endif
        return NP * (S + 1);
    endfunction

    function automatic logic [255:0] tt_or();
        logic [255:0] t = '0;
        for (int p = 1; p < NP; p++) t[p] = 1'b1;
        return t;
    endfunction

    function automatic logic [255:0] tt_and();
        logic [255:0] t = '0;
        t[NP-1] = 1'b1;
        return t;
    endfunction

    // Model: edges elapsed since the accepted start, plus the gate truth table for that run.
    bit           m_started = 1'b0;
    int           m_k = 0;
    int           m_L = 0;
    logic [255:0] m_tt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_k       <= 0;
            m_L       <= 0;
        end else if (start && (!m_started || m_k >= m_L)) begin
            m_started <= 1'b1;
            m_k       <= 0;
            m_L       <= run_len(gate_tt);
            m_tt      <= gate_tt;
        end else if (m_started && m_k < m_L) begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        int samples, pat, err, first;
        bit fv, e_busy, e_done;
        samples = 0; pat = 0; err = 0; first = 0; fv = 0; e_busy = 0; e_done = 0;
        if (m_started) begin
            samples = m_k / (S + 1);
            pat     = (m_k < m_L) ? m_k / (S + 1) : m_L / (S + 1) - 1;
            for (int p = 0; p < samples; p++) begin
                if (is_bad(m_tt, p)) begin
                    err++;
                    if (!fv) begin
                        fv    = 1'b1;
                        first = p;
                    end
                end
            end
            e_busy = (m_k < m_L);
            e_done = (m_k >= m_L);
        end
        check("cmp_dut_in", int'(dut_in), pat);
        check("cmp_busy", int'(busy), int'(e_busy));
        check("cmp_done", int'(done), int'(e_done));
        check("cmp_pass", int'(pass), int'(e_done && err == 0));
        check("cmp_err_cnt", int'(err_cnt), err);
        check("cmp_ff_valid", int'(first_fail_valid), int'(fv));
        check("cmp_ff_vec", int'(first_fail_vec), first);
    end

    // Launches a run and returns edges from the start edge to done; pokes re-pulse start at those edges.
    task automatic run(input logic [255:0] tt, input int poke1, input int poke2, output int cyc);
        @(negedge clk);
        gate_tt = tt;
        start   = 1'b1;
        cyc     = 0;
        @(negedge clk);
        while (!done && cyc < 1000) begin
            start = (cyc == poke1 || cyc == poke2);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("run_timeout", int'(cyc < 1000), 1);
    endtask

    task automatic pulse_reset(input int hold_edges);
        #2 rst_n = 1'b0;
        #1;
        check("rst_dut_in", int'(dut_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_ff_valid", int'(first_fail_valid), 0);
        repeat (hold_edges) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic [255:0] t;
        repeat (3) @(negedge clk);
        check("reset_dut_in", int'(dut_in), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pass", int'(pass), 0);
        check("reset_err_cnt", int'(err_cnt), 0);
        check("reset_ff_valid", int'(first_fail_valid), 0);
        check("reset_ff_vec", int'(first_fail_vec), 0);
        #2 rst_n = 1'b1;

`ifdef OR_GATE_CHECKER_STOP_ON_FAIL_EN
        run('0, -1, -1, c);
        check("sof_len", c, 6);
        check("sof_err_cnt", int'(err_cnt), 1);
        check("sof_dut_in", int'(dut_in), 1);
        check("sof_ff_vec", int'(first_fail_vec), 1);
        check("sof_pass", int'(pass), 0);
        run(tt_or(), -1, -1, c);
        check("sof_or_len", c, 24);
        check("sof_or_pass", int'(pass), 1);
`else
        run(tt_or(), -1, -1, c);
        check("or_len", c, 8);
        check("or_pass", int'(pass), 1);
        check("or_err_cnt", int'(err_cnt), 0);
        check("or_ff_valid", int'(first_fail_valid), 0);
        run('0, -1, -1, c);
        check("sa0_err_cnt", int'(err_cnt), 3);
        check("sa0_ff_vec", int'(first_fail_vec), 1);
        check("sa0_pass", int'(pass), 0);
        check("sa0_done", int'(done), 1);
        run(tt_and(), -1, -1, c);
        check("and_err_cnt", int'(err_cnt), 2);
        check("and_ff_vec", int'(first_fail_vec), 1);
        @(negedge clk);
        gate_tt = tt_or();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_dut_in", int'(dut_in), 2);
        pulse_reset(2);
        run(tt_or(), -1, -1, c);
        check("rerun_pass", int'(pass), 1);
        check("rerun_err_cnt", int'(err_cnt), 0);
        run('0, 3, 7, c);
        check("poke_len", c, 8);
        check("poke_err_cnt", int'(err_cnt), 3);
        run(tt_or(), -1, -1, c);
        check("second_err_cnt", int'(err_cnt), 0);
        check("second_pass", int'(pass), 1);
`endif

        for (int i = 0; i < 30; i++) begin
            t = '0;
            if ($urandom_range(0, 2) == 0) t = tt_or();
            else for (int p = 0; p < NP; p++) t[p] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                gate_tt = t;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, NP * (S + 1))) @(negedge clk);
                pulse_reset($urandom_range(1, 3));
            end else begin
                run(t, int'($urandom_range(0, NP * (S + 1))), int'($urandom_range(0, NP * (S + 1))), c);
                check("rand_len", c, run_len(t));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or_gate_checker.md
Name: or_gate_checker

Overview:
- Sequential self-test engine for the team's OR gate implementations: the initiator side that drives a gate-under-test and checks its response.
- On start, walks every input pattern of an N_IN-input OR gate and compares the gate's output against an internal reference.
- Reports the mismatch count and the first failing pattern.
- Sits beside any OR gate variant (dataflow, behavioural, structural) in a bench or BIST wrapper.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..8.
- SETTLE_CYC, 1, clock cycles a pattern is held before the output is sampled; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- dut_in  output  N_IN  registered pattern driven to the gate-under-test.
- dut_y  input  1  gate-under-test output.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  done and zero mismatches.
- err_cnt  output  N_IN+1  mismatch count for the current or last run.
- first_fail_valid  output  1  at least one mismatch recorded this run.
- first_fail_vec  output  N_IN  pattern of the first mismatch.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low. All state is registered on clk.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE --start--> SETTLE:
  - pattern<=0, settle counter<=SETTLE_CYC-1.
  - err_cnt, first_fail_valid and first_fail_vec cleared.
  - done<=0, busy<=1.
- SETTLE: decrement the settle counter each cycle; when it is 0, go to SAMPLE. The state lasts exactly SETTLE_CYC cycles.
- SAMPLE (one cycle):
  - expected = OR-reduction of pattern.
  - On dut_y != expected: err_cnt+1; if first_fail_valid=0, capture first_fail_vec<=pattern and set first_fail_valid.
  - If pattern == all-ones: go to DONE (busy<=0, done<=1).
  - Otherwise: pattern+1, reload the settle counter, go to SETTLE.
- dut_in always equals pattern (register output, no glitch).
- Cost per pattern is SETTLE_CYC+1 cycles. A run takes 2^N_IN*(SETTLE_CYC+1) cycles from the start edge to done rising.
- err_cnt width N_IN+1 holds the maximum 2^N_IN, so no saturation is needed.
- pass = done & (err_cnt==0), registered with done.
- Counter wrap: the pattern counter is N_IN+1 bits wide; termination comes from the all-ones compare, never from overflow.
- start while busy: ignored, with no effect on the counters.
- start in the same cycle the run completes (SAMPLE of all-ones): ignored. It must be re-issued in DONE.
- Reset mid-run: outputs return to reset values immediately and asynchronously. No partial results are retained.
- dut_y is sampled only in SAMPLE; its value in other states is don't-care.

Optional Feature:
- Macro: OR_GATE_CHECKER_STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE after recording. err_cnt is then 1 and first_fail_vec is valid; the remaining patterns are not driven; dut_in holds the failing pattern.
- Undefined: all 2^N_IN patterns are always exercised, as described in Behaviour.

Decomposition:
- Shared package or_gate_pkg holds:
  - the state encoding typedef (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the MAX_N_IN=8 constant;
  - the cycles-per-run helper function.
- One natural sub-module: or_gate_ref, a combinational N_IN-input OR-reduction producing expected. It keeps the golden model separate and reusable by other checkers.

Test Plan:
- Correct gate (N_IN=2, SETTLE_CYC=1), start pulse -> dut_in steps 0,1,2,3; done rises 8 cycles after start; pass=1, err_cnt=0, first_fail_valid=0.
- Faulty gate with y stuck-at-0 -> err_cnt=3, first_fail_vec=2'b01, pass=0, done=1.
- Faulty gate with y = a&b (N_IN=2) -> mismatches at 01 and 10; err_cnt=2, first_fail_vec=2'b01.
- rst_n low during pattern 2, then released; start again with a correct gate -> all outputs 0 during reset; new run completes with pass=1 and err_cnt=0.
- start pulsed again during busy, and again coincident with the final SAMPLE -> both ignored; run length unchanged at 8 cycles; a start in DONE launches a second run that clears err_cnt.
- With OR_GATE_CHECKER_STOP_ON_FAIL_EN defined, stuck-at-0 gate, N_IN=3, SETTLE_CYC=2 -> done at pattern 3'b001 after 6 cycles; err_cnt=1, dut_in holds 3'b001.
